// File: rtl/dct_pkg.sv
// rtl/dct_pkg.sv - shared constants and types for the 8x8 DCT transpose sequencer
package dct_pkg;
    localparam int N     = 8;
    localparam int LOG2N = 3;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DRAIN
    } state_t;

    // Flat block index: upper LOG2N bits are the outer index, lower the inner.
    typedef logic [2*LOG2N-1:0] idx_t;
endpackage

// File: rtl/dct_tmem.sv
// rtl/dct_tmem.sv - 64-entry transpose register file, one write port, one async read port
module dct_tmem
    import dct_pkg::*;
#(
    parameter int bit_width = 16
) (
    input  logic                 clk,
    input  logic                 we,
    input  idx_t                 waddr,
    input  logic [bit_width-1:0] wdata,
    input  idx_t                 raddr,
    output logic [bit_width-1:0] rdata
);
    logic [bit_width-1:0] mem_q [N*N];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/dct_transpose_seq.sv
// rtl/dct_transpose_seq.sv - fills one 8x8 block row-major, drains it column-major
module dct_transpose_seq #(
    parameter int bit_width = 16,
    parameter int N         = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [bit_width-1:0] in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [bit_width-1:0] out_data,
    output logic [2:0]                  out_col,
    output logic [2:0]                  out_row,
    output logic                        block_done,
    output logic                        busy
);
    localparam int            L        = dct_pkg::LOG2N;
    localparam dct_pkg::idx_t LAST_IDX = dct_pkg::idx_t'(N * N - 1);

    dct_pkg::state_t             state_q, state_d;
    dct_pkg::idx_t               wr_cnt_q, wr_cnt_d;
    dct_pkg::idx_t               rd_cnt_q, rd_cnt_d;
    logic signed [bit_width-1:0] out_data_q, out_data_d;
    logic                        block_done_q, block_done_d;

    logic                        accept;
    logic                        handshake;
    dct_pkg::idx_t               rd_next;
    dct_pkg::idx_t               raddr;
    logic [bit_width-1:0]        rdata;

    assign in_ready   = (state_q == dct_pkg::FILL);
    assign out_valid  = (state_q == dct_pkg::DRAIN);
    assign accept     = in_valid && in_ready;
    assign handshake  = out_valid && out_ready;
    assign out_data   = out_data_q;
    assign out_row    = rd_cnt_q[L-1:0];
    assign out_col    = rd_cnt_q[2*L-1:L];
    assign block_done = block_done_q;
    assign busy       = (state_q == dct_pkg::DRAIN) ||
                        ((state_q == dct_pkg::FILL) && (wr_cnt_q != '0));

    // Prefetch the element presented after this cycle: entry 0 when the fill completes,
    // otherwise the successor of rd_cnt. Reading swaps the index halves (transpose).
    assign rd_next = (state_q == dct_pkg::DRAIN) ? rd_cnt_q + 6'd1 : '0;
    assign raddr   = {rd_next[L-1:0], rd_next[2*L-1:L]};

    dct_tmem #(
        .bit_width(bit_width)
    ) u_tmem (
        .clk  (clk),
        .we   (accept),
        .waddr(wr_cnt_q),
        .wdata(in_data),
        .raddr(raddr),
        .rdata(rdata)
    );

    always_comb begin
        state_d      = state_q;
        wr_cnt_d     = wr_cnt_q;
        rd_cnt_d     = rd_cnt_q;
        out_data_d   = out_data_q;
        block_done_d = 1'b0;
        case (state_q)
            dct_pkg::IDLE: begin
                state_d = dct_pkg::FILL;
            end
            dct_pkg::FILL: begin
                if (accept) begin
                    if (wr_cnt_q == LAST_IDX) begin
                        state_d    = dct_pkg::DRAIN;
                        wr_cnt_d   = '0;
                        rd_cnt_d   = '0;
                        out_data_d = $signed(rdata);
                    end else begin
                        wr_cnt_d = wr_cnt_q + 6'd1;
                    end
                end
            end
            dct_pkg::DRAIN: begin
                if (handshake) begin
                    if (rd_cnt_q == LAST_IDX) begin
                        state_d      = dct_pkg::FILL;
                        wr_cnt_d     = '0;
                        rd_cnt_d     = '0;
                        block_done_d = 1'b1;
                    end else begin
                        rd_cnt_d   = rd_next;
                        out_data_d = $signed(rdata);
                    end
                end
            end
            default: begin
                state_d = dct_pkg::IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= dct_pkg::IDLE;
            wr_cnt_q     <= '0;
            rd_cnt_q     <= '0;
            out_data_q   <= '0;
            block_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_cnt_q     <= wr_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            out_data_q   <= out_data_d;
            block_done_q <= block_done_d;
        end
    end
endmodule

// File: tb/tb_dct_transpose_seq.sv
// tb/tb_dct_transpose_seq.sv - self-checking bench for dct_transpose_seq
module tb_dct_transpose_seq;
    localparam int W = 16;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                in_valid = 1'b0;
    logic                out_ready = 1'b0;
    logic signed [W-1:0] in_data = '0;
    logic                in_ready;
    logic                out_valid;
    logic signed [W-1:0] out_data;
    logic [2:0]          out_col;
    logic [2:0]          out_row;
    logic                block_done;
    logic                busy;

    int checks   = 0;
    int failures = 0;

    dct_transpose_seq #(
        .bit_width(W),
        .N(8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_col   (out_col),
        .out_row   (out_row),
        .block_done(block_done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic                rst;
        logic                iv;
        logic signed [W-1:0] d;
        logic                rdy;
        logic                e_ir;
        logic                e_ov;
        logic                e_busy;
        logic                e_done;
    } vec_t;

    typedef struct {
        logic signed [W-1:0] d;
        int                  r;
        int                  c;
    } exp_t;

    logic signed [W-1:0] src[$];
    logic signed [W-1:0] got[$];

    task automatic chk(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: a block is the 64 accepted samples in arrival order; its drain order is
    // column-major over the row-major block. Fill and drain alternate, never overlapping.
    task automatic run_stream(input int vm, input int rm, input int exp_blocks);
        logic signed [W-1:0] blk[$];
        exp_t                expq[$];
        bit                  drain = 1'b0;
        bit                  done_due = 1'b0;
        bit                  acc;
        bit                  hs;
        int                  cyc = 0;
        int                  hs_cnt = 0;
        int                  blocks = 0;
        int                  phase = 0;
        got.delete();
        while ((src.size() > 0 || drain || done_due) && cyc < 3000) begin
            in_valid = (src.size() > 0) && (vm == 0 || $urandom_range(0, 3) != 0);
            in_data  = (src.size() > 0) ? src[0] : '0;
            case (rm)
                0:       out_ready = 1'b1;
                1:       out_ready = (phase % 4 == 0) || (phase % 4 == 3);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            phase++;
            #1;
            chk("in_ready", in_ready, !drain);
            chk("out_valid", out_valid, drain);
            chk("block_done", block_done, done_due);
            chk("busy", busy, drain || blk.size() > 0);
            if (drain && expq.size() > 0) begin
                chk("out_data", out_data, expq[0].d);
                chk("out_row", out_row, expq[0].r);
                chk("out_col", out_col, expq[0].c);
            end
            acc      = in_valid && !drain;
            hs       = drain && out_ready;
            done_due = 1'b0;
            if (hs) begin
                got.push_back(out_data);
                void'(expq.pop_front());
                hs_cnt++;
                if (expq.size() == 0) begin
                    drain    = 1'b0;
                    done_due = 1'b1;
                    blocks++;
                end
            end
            if (acc) begin
                blk.push_back(src.pop_front());
                if (blk.size() == 64) begin
                    for (int c = 0; c < 8; c++)
                        for (int r = 0; r < 8; r++)
                            expq.push_back('{blk[r*8+c], r, c});
                    blk.delete();
                    drain = 1'b1;
                end
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        chk("run_within_budget", cyc < 3000, 1);
        chk("blocks_done", blocks, exp_blocks);
        chk("handshakes", hs_cnt, 64 * exp_blocks);
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        vec_t tbl[8];
        logic prev_rst;

        tbl[0] = '{1'b0, 1'b0, 16'sd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 16'sd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 16'sd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 16'sd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 16'sd5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 16'sd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 16'sd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 1'b0, 16'sd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

        @(negedge clk);
        prev_rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rst       = tbl[i].rst;
            in_valid  = tbl[i].iv;
            in_data   = tbl[i].d;
            out_ready = tbl[i].rdy;
            #1;
            if (tbl[i].rst && !prev_rst)
                chk("in_ready_before_edge", in_ready, 0);
            prev_rst = tbl[i].rst;
            @(posedge clk);
            @(negedge clk);
            chk("tbl_in_ready", in_ready, tbl[i].e_ir);
            chk("tbl_out_valid", out_valid, tbl[i].e_ov);
            chk("tbl_busy", busy, tbl[i].e_busy);
            chk("tbl_block_done", block_done, tbl[i].e_done);
            chk("tbl_out_data", out_data, 0);
            chk("tbl_out_row", out_row, 0);
            chk("tbl_out_col", out_col, 0);
        end
        in_valid = 1'b0;

        for (int i = 0; i < 64; i++) src.push_back(16'(i));
        run_stream(0, 0, 1);
        chk("ramp_count", got.size(), 64);
        for (int k = 0; k < got.size(); k++)
            chk("ramp_order", got[k], (k % 8) * 8 + k / 8);

        for (int i = 0; i < 64; i++) src.push_back(16'(i));
        run_stream(0, 1, 1);
        chk("stall_count", got.size(), 64);
        for (int k = 0; k < got.size(); k++)
            chk("stall_order", got[k], (k % 8) * 8 + k / 8);

        for (int i = 0; i < 64; i++) src.push_back(16'($urandom));
        src[1] = -16'sd32768;
        src[8] = 16'sd32767;
        run_stream(1, 2, 1);
        if (got.size() == 64) begin
            chk("extreme_idx1", got[1], 32767);
            chk("extreme_idx8", got[8], -32768);
        end else begin
            chk("extreme_count", got.size(), 64);
        end

        for (int i = 0; i < 37; i++) src.push_back(16'($urandom));
        run_stream(0, 0, 0);
        #2 rst = 1'b0;
        #1;
        chk("abort_in_ready", in_ready, 0);
        chk("abort_busy", busy, 0);
        chk("abort_out_valid", out_valid, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_release_in_ready", in_ready, 0);
        @(posedge clk);
        @(negedge clk);
        chk("abort_fill_in_ready", in_ready, 1);
        chk("abort_fill_busy", busy, 0);
        for (int i = 0; i < 64; i++) src.push_back(16'(100 + i));
        run_stream(0, 0, 1);
        if (got.size() > 0) chk("abort_first_out", got[0], 100);
        else chk("abort_first_out_count", got.size(), 64);

        for (int i = 0; i < 128; i++) src.push_back(16'($urandom));
        run_stream(0, 0, 2);

        for (int i = 0; i < 128; i++) src.push_back(16'($urandom));
        run_stream(1, 2, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
